requant_activate_unit: RTL and testbench

- Consumer side of the array output buffer's single read port: pops unquantized int32 results (value, row, col) using the valid/consume handshake.
- Requantizes each result TFLite-style: fixed-point multiply, rounding right shift, zero-point add, activation clamp.
- Emits int8 results with a linear output address to the output-tensor write path. 3-stage pipeline, one result per cycle, full backpressure.

---
 rtl/requant_activate_unit_pkg.sv | 39 +++
 rtl/requant_activate_unit_rounding_shift_clamp.sv | 39 +++
 rtl/requant_activate_unit.sv | 83 ++++++++
 tb/tb_requant_activate_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/requant_activate_unit_pkg.sv
// Shared types and Q31 constants for the requantize/activate datapath.
package sys_types;

    typedef logic signed [7:0]  int8_t;
    typedef logic signed [31:0] int32_t;

    localparam int32_t INT32_MIN = 32'sh8000_0000;
    localparam int32_t INT32_MAX = 32'sh7FFF_FFFF;

    localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
    localparam logic signed [63:0] NUDGE_NEG = -64'sd1073741823;
    localparam logic signed [63:0] Q31_BIAS  = 64'sd2147483647;

    // INT32_MIN * INT32_MIN is the only operand pair whose product reaches 2^62
    localparam logic signed [63:0] SAT_PROD  = 64'sh4000_0000_0000_0000;

    typedef struct packed {
        int32_t     mult;
        logic [4:0] shift;
        int8_t      zero_point;
        int8_t      act_min;
        int8_t      act_max;
    } requant_cfg_t;

    // Saturating rounding doubling high multiply, starting from the full 64-bit product
    function automatic int32_t q31_high_mul(input logic signed [63:0] prod);
        logic signed [63:0] sum;
        logic signed [63:0] biased;
        int32_t             res;
        sum    = prod + (prod[63] ? NUDGE_NEG : NUDGE_POS);
        biased = sum + (sum[63] ? Q31_BIAS : 64'sd0);
        res    = int32_t'(biased >>> 31);
        if (prod == SAT_PROD) begin
            res = INT32_MAX;
        end
        return res;
    endfunction

endpackage

// File: rtl/requant_activate_unit_rounding_shift_clamp.sv
// Combinational rounding right shift, zero-point add and activation clamp.
module rounding_shift_clamp
    import sys_types::*;
(
    input  int32_t     hi,
    input  logic [4:0] shift,
    input  int8_t      zero_point,
    input  int8_t      act_min,
    input  int8_t      act_max,
    output int8_t      y
);

    logic [31:0]        mask;
    logic [31:0]        rem;
    logic [31:0]        thr;
    int32_t             shifted;
    int32_t             r;
    logic signed [32:0] sum;
    logic signed [32:0] lo_bound;
    logic signed [32:0] hi_bound;
    logic signed [32:0] after_min;
    logic signed [32:0] after_max;

    // The upper bound is applied last so an inverted range collapses to act_max
    always_comb begin
        mask      = (32'd1 << shift) - 32'd1;
        rem       = hi & mask;
        thr       = (mask >> 1) + {31'd0, hi[31]};
        shifted   = hi >>> shift;
        r         = shifted + {31'd0, (rem > thr)};
        sum       = {r[31], r} + {{25{zero_point[7]}}, zero_point};
        lo_bound  = {{25{act_min[7]}}, act_min};
        hi_bound  = {{25{act_max[7]}}, act_max};
        after_min = (sum < lo_bound) ? lo_bound : sum;
        after_max = (after_min > hi_bound) ? hi_bound : after_min;
        y         = after_max[7:0];
    end

endmodule

// File: rtl/requant_activate_unit.sv
// Three-stage requantize/activate pipeline between the array output buffer and the int8 tensor writer.
module requant_activate_unit
    import sys_types::*;
#(
    parameter int MAX_N     = 512,
    parameter int N_BITS    = $clog2(MAX_N),
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [31:0]   in_output,
    input  logic [N_BITS-1:0]    in_row,
    input  logic [N_BITS-1:0]    in_col,
    output logic                 in_consume,
    input  logic signed [31:0]   cfg_mult,
    input  logic [4:0]           cfg_shift,
    input  logic signed [7:0]    cfg_zero_point,
    input  logic signed [7:0]    cfg_act_min,
    input  logic signed [7:0]    cfg_act_max,
    input  logic [N_BITS-1:0]    cfg_row_stride,
    output logic                 out_valid,
    output logic signed [7:0]    out_data,
    output logic [ADDR_BITS-1:0] out_addr,
    input  logic                 out_ready,
    output logic                 idle
);

    requant_cfg_t         cfg;
    logic                 stall;
    logic                 v1, v2, v3;
    logic signed [63:0]   prod1;
    logic [ADDR_BITS-1:0] addr1, addr2, addr3;
    int32_t               hi2;
    int8_t                data3;
    int8_t                y;

    assign cfg = '{mult: cfg_mult, shift: cfg_shift, zero_point: cfg_zero_point,
                   act_min: cfg_act_min, act_max: cfg_act_max};

    assign stall      = v3 && !out_ready;
    assign in_consume = in_valid && !stall;
    assign idle       = !v1 && !v2 && !v3 && !in_valid;

    assign out_valid  = v3;
    assign out_data   = data3;
    assign out_addr   = addr3;

    // Only the stage valids are reset; bubbles travel through as valid=0 with stale data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (!stall) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // Address is computed modulo 2^ADDR_BITS, so narrowing the operands first is exact
    always_ff @(posedge clk) begin
        if (!stall) begin
            prod1 <= in_output * cfg.mult;
            addr1 <= ADDR_BITS'(in_row) * ADDR_BITS'(cfg_row_stride) + ADDR_BITS'(in_col);
            hi2   <= q31_high_mul(prod1);
            addr2 <= addr1;
            data3 <= y;
            addr3 <= addr2;
        end
    end

    rounding_shift_clamp u_rounding_shift_clamp (
        .hi         (hi2),
        .shift      (cfg.shift),
        .zero_point (cfg.zero_point),
        .act_min    (cfg.act_min),
        .act_max    (cfg.act_max),
        .y          (y)
    );

endmodule

// File: tb/tb_requant_activate_unit.sv
// Directed vector table plus backpressure and async-reset sequences for requant_activate_unit.
module tb_requant_activate_unit;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic signed [31:0] in_output;
    logic [8:0]         in_row;
    logic [8:0]         in_col;
    logic               in_consume;
    logic signed [31:0] cfg_mult;
    logic [4:0]         cfg_shift;
    logic signed [7:0]  cfg_zero_point;
    logic signed [7:0]  cfg_act_min;
    logic signed [7:0]  cfg_act_max;
    logic [8:0]         cfg_row_stride;
    logic               out_valid;
    logic signed [7:0]  out_data;
    logic [15:0]        out_addr;
    logic               out_ready;
    logic               idle;

    int compared = 0;
    int failed   = 0;

    typedef struct {
        logic signed [31:0] mult;
        logic [4:0]         shift;
        logic signed [7:0]  zp;
        logic signed [7:0]  amin;
        logic signed [7:0]  amax;
        logic signed [31:0] acc;
        logic [8:0]         row;
        logic [8:0]         col;
        logic [8:0]         stride;
        logic signed [7:0]  exp_data;
        logic [15:0]        exp_addr;
    } vec_t;

    vec_t vecs[14];

    localparam logic signed [31:0] M_HALF = 32'sh4000_0000;
    localparam logic signed [31:0] I_MIN  = 32'sh8000_0000;

    requant_activate_unit dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_output      (in_output),
        .in_row         (in_row),
        .in_col         (in_col),
        .in_consume     (in_consume),
        .cfg_mult       (cfg_mult),
        .cfg_shift      (cfg_shift),
        .cfg_zero_point (cfg_zero_point),
        .cfg_act_min    (cfg_act_min),
        .cfg_act_max    (cfg_act_max),
        .cfg_row_stride (cfg_row_stride),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_addr       (out_addr),
        .out_ready      (out_ready),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] sx8(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, $signed(actual), actual, $signed(expected), expected);
        end
    endtask

    task automatic setCfg(input logic signed [31:0] mult, input logic [4:0] shift,
                          input logic signed [7:0] zp, input logic signed [7:0] amin,
                          input logic signed [7:0] amax, input logic [8:0] stride);
        cfg_mult       = mult;
        cfg_shift      = shift;
        cfg_zero_point = zp;
        cfg_act_min    = amin;
        cfg_act_max    = amax;
        cfg_row_stride = stride;
    endtask

    // One beat into an idle pipeline: consumed now, invisible after two edges, visible after three
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        setCfg(v.mult, v.shift, v.zp, v.amin, v.amax, v.stride);
        in_output = v.acc;
        in_row    = v.row;
        in_col    = v.col;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput({tag, "_consume"}, 32'(in_consume), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_valid_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_data"}, sx8(out_data), sx8(v.exp_data));
        checkOutput({tag, "_addr"}, 32'(out_addr), 32'(v.exp_addr));
        @(negedge clk);
        checkOutput({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    initial begin
        int consumes;
        int sent;
        int recv;

        vecs[0]  = '{M_HALF, 5'd0,  8'sd0,   -8'sd128, 8'sd127, 32'sd100,   9'd2,   9'd3,   9'd8,   8'sd50,   16'd19};
        vecs[1]  = '{M_HALF, 5'd1,  -8'sd5,  -8'sd128, 8'sd127, 32'sd101,   9'd5,   9'd7,   9'd10,  8'sd21,   16'd57};
        vecs[2]  = '{M_HALF, 5'd1,  -8'sd5,  -8'sd128, 8'sd127, -32'sd101,  9'd511, 9'd511, 9'd511, -8'sd30,  16'hFE00};
        vecs[3]  = '{M_HALF, 5'd0,  8'sd0,   -8'sd128, 8'sd127, 32'sd1000,  9'd1,   9'd0,   9'd4,   8'sd127,  16'd4};
        vecs[4]  = '{M_HALF, 5'd0,  8'sd0,   -8'sd128, 8'sd127, -32'sd1000, 9'd0,   9'd9,   9'd4,   -8'sd128, 16'd9};
        vecs[5]  = '{M_HALF, 5'd0,  8'sd0,   8'sd0,    8'sd127, -32'sd100,  9'd3,   9'd3,   9'd3,   8'sd0,    16'd12};
        vecs[6]  = '{M_HALF, 5'd0,  8'sd0,   8'sd10,   8'sd5,   32'sd100,   9'd0,   9'd0,   9'd1,   8'sd5,    16'd0};
        vecs[7]  = '{I_MIN,  5'd31, 8'sd0,   -8'sd128, 8'sd127, I_MIN,      9'd1,   9'd1,   9'd1,   8'sd1,    16'd2};
        vecs[8]  = '{I_MIN,  5'd31, 8'sd0,   -8'sd128, 8'sd127, 32'sd0,     9'd0,   9'd1,   9'd1,   8'sd0,    16'd1};
        vecs[9]  = '{M_HALF, 5'd2,  8'sd0,   -8'sd128, 8'sd127, 32'sd6,     9'd0,   9'd2,   9'd0,   8'sd1,    16'd2};
        vecs[10] = '{M_HALF, 5'd2,  8'sd0,   -8'sd128, 8'sd127, -32'sd6,    9'd0,   9'd3,   9'd0,   -8'sd1,   16'd3};
        vecs[11] = '{M_HALF, 5'd2,  8'sd0,   -8'sd128, 8'sd127, -32'sd4,    9'd0,   9'd4,   9'd0,   -8'sd1,   16'd4};
        vecs[12] = '{M_HALF, 5'd0,  8'sd100, -8'sd128, 8'sd127, 32'sd100,   9'd0,   9'd5,   9'd0,   8'sd127,  16'd5};
        vecs[13] = '{-M_HALF, 5'd0, 8'sd0,   -8'sd128, 8'sd127, 32'sd100,   9'd0,   9'd6,   9'd0,   -8'sd50,  16'd6};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_output = '0;
        in_row    = '0;
        in_col    = '0;
        out_ready = 1'b1;
        setCfg(32'sd0, 5'd0, 8'sd0, -8'sd128, 8'sd127, 9'd0);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_consume", 32'(in_consume), 32'd0);
        checkOutput("reset_idle", 32'(idle), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], $sformatf("v%0d", i));
        end

        // Backpressure: six beats against a stalled sink, then drain
        @(negedge clk);
        setCfg(M_HALF, 5'd0, 8'sd0, -8'sd128, 8'sd127, 9'd8);
        out_ready = 1'b0;
        consumes  = 0;
        sent      = 0;
        recv      = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (sent < 6) begin
                in_valid  = 1'b1;
                in_output = 32'(20 * (sent + 1));
                in_row    = 9'd0;
                in_col    = 9'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_consume) begin
                consumes++;
                sent++;
            end
            if (cyc >= 4) begin
                checkOutput($sformatf("bp_hold_valid_c%0d", cyc), 32'(out_valid), 32'd1);
                checkOutput($sformatf("bp_hold_data_c%0d", cyc), sx8(out_data), 32'd10);
            end
        end
        checkOutput("bp_consumes", 32'(consumes), 32'd3);
        checkOutput("bp_consume_low", 32'(in_consume), 32'd0);

        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (sent < 6) begin
                in_valid  = 1'b1;
                in_output = 32'(20 * (sent + 1));
                in_row    = 9'd0;
                in_col    = 9'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_consume) sent++;
            if (out_valid) begin
                checkOutput($sformatf("bp_drain_data%0d", recv), sx8(out_data), 32'(10 * (recv + 1)));
                checkOutput($sformatf("bp_drain_addr%0d", recv), 32'(out_addr), 32'(recv));
                recv++;
            end
        end
        checkOutput("bp_recv_count", 32'(recv), 32'd6);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput("bp_no_dup_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_idle", 32'(idle), 32'd1);

        // Async reset between clock edges while results are in flight
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_output = 32'(40 + cyc);
            in_row    = 9'd1;
            in_col    = 9'(cyc);
        end
        @(negedge clk);
        checkOutput("rst_pre_valid", 32'(out_valid), 32'd1);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("rst_async_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_async_idle", 32'(idle), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_release_idle", 32'(idle), 32'd1);
        applyStimulus(vecs[0], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
